// File: rtl/instr_enc_pkg.sv
// Shared types, field constants and the instruction encoder for the loader.
// ENC_ILLEGAL_CHECK_EN selects NOP substitution for illegal kinds.
package instr_enc_pkg;

    typedef enum logic [2:0] {
        K_DP_IMM = 3'b000,
        K_DP_REG = 3'b001,
        K_LDR    = 3'b010,
        K_STR    = 3'b011,
        K_B      = 3'b100
    } kind_t;

    localparam logic [1:0]  OP_DP     = 2'b00;
    localparam logic [1:0]  OP_MEM    = 2'b01;
    localparam logic [1:0]  OP_B      = 2'b10;
    localparam logic [5:0]  FUNCT_LDR = 6'b011001;
    localparam logic [5:0]  FUNCT_STR = 6'b011000;
    localparam logic [1:0]  FUNCT_B   = 2'b10;
    localparam logic [27:0] NOP_BODY  = 28'h1A00000;

    function automatic logic [31:0] encode(
        input logic [2:0]  kind,
        input logic [3:0]  cond,
        input logic [3:0]  cmd,
        input logic        s,
        input logic [3:0]  rn,
        input logic [3:0]  rd,
        input logic [11:0] src2,
        input logic [23:0] imm24
    );
        logic [31:0] w;
        case (kind)
            K_DP_IMM: w = {cond, OP_DP, 1'b1, cmd, s, rn, rd, src2};
            K_DP_REG: w = {cond, OP_DP, 1'b0, cmd, s, rn, rd, src2};
            K_LDR:    w = {cond, OP_MEM, FUNCT_LDR, rn, rd, src2};
            K_STR:    w = {cond, OP_MEM, FUNCT_STR, rn, rd, src2};
            K_B:      w = {cond, OP_B, FUNCT_B, imm24};
`ifdef ENC_ILLEGAL_CHECK_EN
            default:  w = {cond, NOP_BODY};
`else
            default:  w = {cond, 28'h0};
`endif
        endcase
        return w;
    endfunction

endpackage

// File: rtl/enc_fifo.sv
// Synchronous FIFO for encoded words; flush empties it on the next edge.
module enc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];
    // A pop frees the slot the push needs, so push-on-full is legal alongside a pop.
    assign do_push = push_i && (!full_o || pop_i);
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (do_push && !reset && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CW'(1);
        end
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes instruction fields and writes them to consecutive imem words per session.
// ENC_ILLEGAL_CHECK_EN enables the illegal-kind pulse and NOP substitution.
module instr_encoder_loader
    import instr_enc_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
    parameter int          MEM_WORDS  = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_last,
    input  logic [2:0]  in_kind,
    input  logic [3:0]  in_cond,
    input  logic [3:0]  in_cmd,
    input  logic        in_s,
    input  logic [3:0]  in_rn,
    input  logic [3:0]  in_rd,
    input  logic [11:0] in_src2,
    input  logic [23:0] in_imm24,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        illegal
);
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_ERR} state_t;
    localparam int IW = $clog2(MEM_WORDS) + 1;

    state_t        state_q, state_d;
    logic [IW-1:0] widx_q, widx_d;
    logic          ovf_q, ovf_d;
    logic          accept, fifo_pop, fifo_flush, fifo_full, fifo_empty;
    logic [32:0]   fifo_rdata;

    assign accept   = in_valid && in_ready;
    assign in_ready = (state_q == S_RUN) && !fifo_full;
    assign busy     = (state_q != S_IDLE);
    assign overflow = ovf_q;

`ifdef ENC_ILLEGAL_CHECK_EN
    assign illegal = accept && (in_kind > 3'd4);
`else
    assign illegal = 1'b0;
`endif

    enc_fifo #(.DEPTH(FIFO_DEPTH), .W(33)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (accept),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .wdata_i ({encode(in_kind, in_cond, in_cmd, in_s, in_rn, in_rd, in_src2, in_imm24), in_last}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d    = state_q;
        widx_d     = widx_q;
        ovf_d      = ovf_q;
        fifo_pop   = 1'b0;
        fifo_flush = 1'b0;
        imem_we    = 1'b0;
        imem_addr  = '0;
        imem_wdata = '0;
        done       = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_RUN;
                widx_d  = '0;
                ovf_d   = 1'b0;
            end
            S_RUN, S_DRAIN: begin
                if (state_q == S_RUN && accept && in_last) state_d = S_DRAIN;
                if (!fifo_empty) begin
                    // The counter parks at MEM_WORDS; the next pop aborts instead of wrapping.
                    if (widx_q >= IW'(MEM_WORDS)) begin
                        ovf_d      = 1'b1;
                        fifo_flush = 1'b1;
                        state_d    = S_ERR;
                    end else begin
                        fifo_pop   = 1'b1;
                        imem_we    = 1'b1;
                        imem_addr  = BASE_ADDR + (32'(widx_q) << 2);
                        imem_wdata = fifo_rdata[32:1];
                        widx_d     = widx_q + IW'(1);
                        if (fifo_rdata[0]) state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            widx_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            widx_q  <= widx_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench: a 64-word and a 4-word loader share stimulus; writes are scored against a field-level model.
module tb_instr_encoder_loader;

    typedef struct {
        logic [2:0]  kind;
        logic [3:0]  cond;
        logic [3:0]  cmd;
        logic        s;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [11:0] src2;
        logic [23:0] imm24;
    } ins_t;

    typedef struct {
        ins_t        ins;
        logic [31:0] exp;
    } vec_t;

    logic clk = 0, reset = 1, start = 0, in_valid = 0, in_last = 0, in_s = 0;
    logic [2:0]  in_kind = 0;
    logic [3:0]  in_cond = 0, in_cmd = 0, in_rn = 0, in_rd = 0;
    logic [11:0] in_src2 = 0;
    logic [23:0] in_imm24 = 0;
    logic        rdy1, we1, busy1, done1, ovf1, ill1;
    logic        rdy2, we2, busy2, done2, ovf2, ill2;
    logic [31:0] addr1, data1, addr2, data2;

    always #5 clk = ~clk;

    instr_encoder_loader dut1 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy1),
        .in_last(in_last), .in_kind(in_kind), .in_cond(in_cond), .in_cmd(in_cmd), .in_s(in_s),
        .in_rn(in_rn), .in_rd(in_rd), .in_src2(in_src2), .in_imm24(in_imm24),
        .imem_we(we1), .imem_addr(addr1), .imem_wdata(data1), .busy(busy1), .done(done1),
        .overflow(ovf1), .illegal(ill1));

    instr_encoder_loader #(.MEM_WORDS(4)) dut2 (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(rdy2),
        .in_last(in_last), .in_kind(in_kind), .in_cond(in_cond), .in_cmd(in_cmd), .in_s(in_s),
        .in_rn(in_rn), .in_rd(in_rd), .in_src2(in_src2), .in_imm24(in_imm24),
        .imem_we(we2), .imem_addr(addr2), .imem_wdata(data2), .busy(busy2), .done(done2),
        .overflow(ovf2), .illegal(ill2));

    int n_cmp = 0, n_err = 0;
    int cyc = 0, done1_cnt, done2_cnt, ill_cnt, stall_cnt, acc_cyc, we_cyc, done_cyc;
    logic [63:0] w1[$], w2[$];
    ins_t sq[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (in_valid && rdy1 && in_last) acc_cyc = cyc;
        if (we1) begin
            if (w1.size() == 0) we_cyc = cyc;
            w1.push_back({addr1, data1});
        end
        if (we2) w2.push_back({addr2, data2});
        if (done1) begin done1_cnt++; done_cyc = cyc; end
        if (done2) done2_cnt++;
        if (ill1) ill_cnt++;
        if (in_valid && !rdy1 && busy1) stall_cnt++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference encoding built from the field positions of the instruction format.
    function automatic logic [31:0] model_enc(input ins_t x);
        logic [31:0] c = 32'(x.cond) << 28;
        logic [31:0] regs = (32'(x.rn) << 16) | (32'(x.rd) << 12) | 32'(x.src2);
        case (x.kind)
            3'd0: return c | (32'h1 << 25) | (32'(x.cmd) << 21) | (32'(x.s) << 20) | regs;
            3'd1: return c | (32'(x.cmd) << 21) | (32'(x.s) << 20) | regs;
            3'd2: return c | (32'h59 << 20) | regs;
            3'd3: return c | (32'h58 << 20) | regs;
            3'd4: return c | (32'hA << 24) | 32'(x.imm24);
`ifdef ENC_ILLEGAL_CHECK_EN
            default: return c | 32'h01A0_0000;
`else
            default: return c;
`endif
        endcase
    endfunction

    function automatic ins_t rnd_ins(input int max_kind);
        ins_t x;
        x.kind = 3'($urandom_range(max_kind)); x.cond = 4'($urandom); x.cmd = 4'($urandom);
        x.s = 1'($urandom); x.rn = 4'($urandom); x.rd = 4'($urandom);
        x.src2 = 12'($urandom); x.imm24 = 24'($urandom);
        return x;
    endfunction

    task automatic drive(input ins_t x, input logic last);
        in_kind = x.kind; in_cond = x.cond; in_cmd = x.cmd; in_s = x.s;
        in_rn = x.rn; in_rd = x.rd; in_src2 = x.src2; in_imm24 = x.imm24; in_last = last;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
    endtask

    // Runs sq as one session on both loaders and scores writes, done, overflow, illegal.
    task automatic session(input string nm, input int gap_pct);
        int i = 0, budget = 0, n = sq.size(), n_ill = 0;
        w1.delete(); w2.delete();
        done1_cnt = 0; done2_cnt = 0; ill_cnt = 0; stall_cnt = 0;
        pulse_start();
        @(negedge clk); chk({nm, " ovf2_cleared"}, 64'(ovf2), 64'(0));
        @(posedge clk); #1;
        while (i < n && budget < 1000) begin
            drive(sq[i], i == n - 1);
            in_valid = ($urandom_range(99) >= gap_pct);
            @(negedge clk);
            if (in_valid && rdy1) i++;
            @(posedge clk); #1;
            budget++;
        end
        in_valid = 0; in_last = 0;
        budget = 0;
        while ((busy1 || busy2) && budget < 200) begin @(posedge clk); #1; budget++; end
        chk({nm, " finished"}, 64'(budget < 200 && i == n), 64'(1));
        repeat (2) @(posedge clk);
        #1;
        chk({nm, " w1_count"}, 64'(w1.size()), 64'(n));
        for (int j = 0; j < n && j < w1.size(); j++) begin
            chk({nm, " w1_word"}, w1[j], {32'(j * 4), model_enc(sq[j])});
            if (sq[j].kind > 3'd4) n_ill++;
        end
        chk({nm, " w2_count"}, 64'(w2.size()), 64'(n > 4 ? 4 : n));
        for (int j = 0; j < w2.size() && j < n; j++)
            chk({nm, " w2_word"}, w2[j], {32'(j * 4), model_enc(sq[j])});
        chk({nm, " done1"}, 64'(done1_cnt), 64'(1));
        chk({nm, " done2"}, 64'(done2_cnt), 64'(n > 4 ? 0 : 1));
        chk({nm, " ovf1"}, 64'(ovf1), 64'(0));
        chk({nm, " ovf2"}, 64'(ovf2), 64'(n > 4 ? 1 : 0));
`ifdef ENC_ILLEGAL_CHECK_EN
        chk({nm, " illegal"}, 64'(ill_cnt), 64'(n_ill));
`else
        chk({nm, " illegal"}, 64'(ill_cnt), 64'(0));
`endif
    endtask

    vec_t tbl[6];

    initial begin
        int wsz;
        ins_t x;
        tbl[0].ins = '{3'd0, 4'hE, 4'h4, 1'b0, 4'h1, 4'h2, 12'h005, 24'h0}; tbl[0].exp = 32'hE281_2005;
        tbl[1].ins = '{3'd2, 4'hE, 4'h0, 1'b0, 4'h0, 4'h3, 12'h008, 24'h0}; tbl[1].exp = 32'hE590_3008;
        tbl[2].ins = '{3'd3, 4'hE, 4'h0, 1'b0, 4'h0, 4'h3, 12'h00C, 24'h0}; tbl[2].exp = 32'hE580_300C;
        tbl[3].ins = '{3'd4, 4'hA, 4'h0, 1'b0, 4'h0, 4'h0, 12'h000, 24'hFFFFFE}; tbl[3].exp = 32'hAAFF_FFFE;
        tbl[4].ins = '{3'd1, 4'h0, 4'hD, 1'b1, 4'h0, 4'h1, 12'h003, 24'h0}; tbl[4].exp = 32'h01B0_1003;
`ifdef ENC_ILLEGAL_CHECK_EN
        tbl[5].ins = '{3'd6, 4'hE, 4'h7, 1'b1, 4'h5, 4'h6, 12'h123, 24'h0}; tbl[5].exp = 32'hE1A0_0000;
`else
        tbl[5].ins = '{3'd6, 4'hE, 4'h7, 1'b1, 4'h5, 4'h6, 12'h123, 24'h0}; tbl[5].exp = 32'hE000_0000;
`endif

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset outputs", {58'(0), rdy1, we1, busy1, done1, ovf1, ill1}, 64'(0));
        chk("reset addr/data", {addr1, data1}, 64'(0));
        @(posedge clk); #1 reset = 0;

        foreach (tbl[k]) begin
            sq.delete(); sq.push_back(tbl[k].ins);
            session($sformatf("tbl%0d", k), 0);
            chk($sformatf("tbl%0d const", k), w1.size() > 0 ? w1[0] : 64'hDEAD, {32'h0, tbl[k].exp});
            chk($sformatf("tbl%0d lat_we", k), 64'(we_cyc - acc_cyc), 64'(1));
            chk($sformatf("tbl%0d lat_done", k), 64'(done_cyc - acc_cyc), 64'(2));
        end

        sq.delete(); sq.push_back(tbl[1].ins); sq.push_back(tbl[2].ins);
        session("ldr_str", 0);

        sq.delete();
        for (int k = 0; k < 10; k++) begin x = rnd_ins(0); x.kind = 3'd1; sq.push_back(x); end
        session("dpreg10", 0);
        chk("dpreg10 no_stall", 64'(stall_cnt), 64'(0));

        sq.delete();
        for (int k = 0; k < 6; k++) sq.push_back(rnd_ins(4));
        session("ovf6", 0);

        for (int r = 0; r < 10; r++) begin
            sq.delete();
            for (int k = 0; k < 1 + int'($urandom_range(8)); k++) sq.push_back(rnd_ins(7));
            session($sformatf("rnd%0d", r), 30);
        end

        // Reset in the middle of a session: nothing may be written after the reset edge.
        w1.delete(); w2.delete();
        pulse_start();
        for (int k = 0; k < 3; k++) begin
            drive(rnd_ins(4), 1'b0); in_valid = 1;
            @(posedge clk); #1;
        end
        in_valid = 0; reset = 1;
        @(posedge clk); #1;
        wsz = w1.size() + w2.size();
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("midreset no_write", 64'(w1.size() + w2.size()), 64'(wsz));
        chk("midreset busy", {62'(0), busy1, busy2}, 64'(0));
        #1 reset = 0;
        sq.delete(); sq.push_back(tbl[0].ins); sq.push_back(tbl[4].ins);
        session("after_reset", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
